temperature_serial_alu: RTL and testbench

TEMPERATURE_SERIAL_ALU -- requirements
Module: temperature_serial_alu

---
 rtl/temp_calc_pkg.sv | 15 +
 rtl/add_sub.sv | 17 +
 rtl/temperature_serial_alu.sv | 134 +++++++++++++
 tb/tb_temperature_serial_alu.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/temp_calc_pkg.sv
// Shared types and constants for the bit-serial temperature add/subtract unit.
package temp_calc_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/add_sub.sv
// One-bit full adder with operand-B inversion for subtraction.
module add_sub (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sel,
    output logic sum,
    output logic cout
);

    logic b_eff;

    assign b_eff = b ^ sel;
    assign sum   = a ^ b_eff ^ cin;
    assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// File: rtl/temperature_serial_alu.sv
// Bit-serial two's complement add/subtract: one bit per cycle through a single
// add_sub cell, LSB first; flags and result publish only when the last bit completes.
module temperature_serial_alu
    import temp_calc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cell_sum;
    logic             cell_cout;

    add_sub u_add_sub (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sel  (sub_q),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    // Next-state, datapath shifting and registered-output decode
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = op_sub;
                    carry_d = (op_sub == OP_SUB);
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = {cell_sum, acc_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = cell_cout;
                cnt_d   = cnt_q + CW'(1);
                // carry_q here is the carry into the MSB bit-cycle
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = {cell_sum, acc_q[WIDTH-1:1]};
                    cout_d   = cell_cout;
                    ovf_d    = carry_q ^ cell_cout;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_temperature_serial_alu.sv
// Directed vector bench for temperature_serial_alu at WIDTH=8.
module tb_temperature_serial_alu;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    temperature_serial_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic [7:0] res;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, verify latency, single done pulse and no partial result
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic iop);
        logic [7:0] prev;
        int         cyc;
        logic       partial;
        prev    = result;
        partial = 1'b0;
        a       = ia;
        b       = ib;
        op_sub  = iop;
        start   = 1'b1;
        tick();
        start  = 1'b0;
        a      = 8'($urandom);
        b      = 8'($urandom);
        op_sub = 1'($urandom);
        cyc    = 1;
        while (!done && cyc < 40) begin
            if (result !== prev) partial = 1'b1;
            if (busy !== 1'b1) partial = 1'b1;
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(WIDTH + 1));
        check("no_partial_or_busy", 32'(partial), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
    endtask

    task automatic after_done();
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int done_cnt;
        logic [7:0] held;

        vecs[0]  = '{8'd25,  8'd17,  1'b0, 8'd42,  1'b0, 1'b0};
        vecs[1]  = '{8'd100, 8'd50,  1'b0, 8'h96,  1'b0, 1'b1};
        vecs[2]  = '{8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1'b0};
        vecs[3]  = '{8'd20,  8'd30,  1'b1, 8'hF6,  1'b0, 1'b0};
        vecs[4]  = '{8'd30,  8'd20,  1'b1, 8'd10,  1'b1, 1'b0};
        vecs[5]  = '{8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1};
        vecs[6]  = '{8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b1};
        vecs[7]  = '{8'h00,  8'h00,  1'b1, 8'h00,  1'b1, 1'b0};
        vecs[8]  = '{8'h80,  8'h80,  1'b0, 8'h00,  1'b1, 1'b1};
        vecs[9]  = '{8'h00,  8'h01,  1'b1, 8'hFF,  1'b0, 1'b0};
        vecs[10] = '{8'h7F,  8'hFF,  1'b1, 8'h80,  1'b0, 1'b1};
        vecs[11] = '{8'hA5,  8'h5A,  1'b0, 8'hFF,  1'b0, 1'b0};

        rst    = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        a      = '0;
        b      = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(carry_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op);
            check($sformatf("result[%0d]", i), 32'(result), 32'(vecs[i].res));
            check($sformatf("cout[%0d]", i), 32'(carry_out), 32'(vecs[i].co));
            check($sformatf("ovf[%0d]", i), 32'(overflow), 32'(vecs[i].ov));
            after_done();
            check($sformatf("result_hold[%0d]", i), 32'(result), 32'(vecs[i].res));
        end

        // start re-pulsed in cycles 3 and 9 of an active 10+20 operation
        done_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            start = (c == 0 || c == 3 || c == 9);
            a     = (c == 0) ? 8'd10 : 8'd99;
            b     = (c == 0) ? 8'd20 : 8'd77;
            op_sub = (c == 0) ? 1'b0 : 1'b1;
            tick();
            if (done) done_cnt++;
            if (c + 1 == 9)  check("restart_done_c9", 32'(done), 32'd1);
            if (c + 1 == 10) check("restart_busy_c10", 32'(busy), 32'd0);
        end
        start = 1'b0;
        check("restart_done_count", 32'(done_cnt), 32'd1);
        check("restart_result", 32'(result), 32'd30);
        check("restart_cout", 32'(carry_out), 32'd0);

        // rst in cycle 4 of an operation aborts it
        held = result;
        check("pre_abort_result", 32'(held), 32'd30);
        done_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            start  = (c == 0);
            a      = 8'd7;
            b      = 8'd9;
            op_sub = 1'b0;
            rst    = (c == 4);
            tick();
            if (done) done_cnt++;
            if (c + 1 == 5) begin
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_result", 32'(result), 32'd0);
                check("abort_cout", 32'(carry_out), 32'd0);
                check("abort_ovf", 32'(overflow), 32'd0);
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_op(8'd5, 8'd3, 1'b0);
        check("post_abort_result", 32'(result), 32'd8);
        after_done();

        // rst and start in the same cycle: reset wins
        rst    = 1'b1;
        start  = 1'b1;
        a      = 8'd1;
        b      = 8'd1;
        op_sub = 1'b0;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_prio_busy", 32'(busy), 32'd0);
        tick();
        check("rst_prio_busy2", 32'(busy), 32'd0);
        check("rst_prio_result", 32'(result), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
